// File: rtl/wm_pkg.sv
// Shared definitions between the washing-machine controller and its plant-side responder.
package wm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_HEAT  = 3'd2,
        ST_WASH  = 3'd3,
        ST_RINSE = 3'd4,
        ST_SPIN  = 3'd5,
        ST_HOLD  = 3'd6,
        ST_ERROR = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        PH_NONE  = 3'd0,
        PH_FILL  = 3'd1,
        PH_HEAT  = 3'd2,
        PH_WASH  = 3'd3,
        PH_RINSE = 3'd4,
        PH_SPIN  = 3'd5
    } phase_t;

    localparam int CMD_W     = 5;
    localparam int CMD_FILL  = 0;
    localparam int CMD_HEAT  = 1;
    localparam int CMD_WASH  = 2;
    localparam int CMD_RINSE = 3;
    localparam int CMD_SPIN  = 4;

    localparam int unsigned DEF_FILL_CYCLES  = 200;
    localparam int unsigned DEF_HEAT_CYCLES  = 300;
    localparam int unsigned DEF_WASH_CYCLES  = 1000;
    localparam int unsigned DEF_RINSE_CYCLES = 600;
    localparam int unsigned DEF_SPIN_CYCLES  = 400;

    function automatic logic is_phase(input state_t s);
        return (s == ST_FILL) || (s == ST_HEAT) || (s == ST_WASH) ||
               (s == ST_RINSE) || (s == ST_SPIN);
    endfunction

    // Only meaningful for a one-hot command; lowest set bit wins otherwise.
    function automatic state_t cmd_to_state(input logic [CMD_W-1:0] cmd);
        if (cmd[CMD_FILL])       return ST_FILL;
        else if (cmd[CMD_HEAT])  return ST_HEAT;
        else if (cmd[CMD_WASH])  return ST_WASH;
        else if (cmd[CMD_RINSE]) return ST_RINSE;
        else if (cmd[CMD_SPIN])  return ST_SPIN;
        else                     return ST_IDLE;
    endfunction

    function automatic phase_t state_to_phase(input state_t s);
        case (s)
            ST_FILL:  return PH_FILL;
            ST_HEAT:  return PH_HEAT;
            ST_WASH:  return PH_WASH;
            ST_RINSE: return PH_RINSE;
            ST_SPIN:  return PH_SPIN;
            default:  return PH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wm_phase_counter.sv
// Saturating phase-duration counter with synchronous clear and a terminal flag at LIMIT-1.
module wm_phase_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal = (count == (limit - CNT_W'(1)));

endmodule

// File: rtl/wm_phase_responder.sv
// Plant model answering the washing-machine controller: runs timed phases, drives actuators,
// reports phase completion and flags command-protocol violations.
module wm_phase_responder
    import wm_pkg::*;
#(
    parameter int               CNT_W        = 16,
    parameter logic [CNT_W-1:0] FILL_CYCLES  = CNT_W'(DEF_FILL_CYCLES),
    parameter logic [CNT_W-1:0] HEAT_CYCLES  = CNT_W'(DEF_HEAT_CYCLES),
    parameter logic [CNT_W-1:0] WASH_CYCLES  = CNT_W'(DEF_WASH_CYCLES),
    parameter logic [CNT_W-1:0] RINSE_CYCLES = CNT_W'(DEF_RINSE_CYCLES),
    parameter logic [CNT_W-1:0] SPIN_CYCLES  = CNT_W'(DEF_SPIN_CYCLES)
) (
    input  logic clock,
    input  logic reset_n,
    input  logic lid,
    input  logic water_Intake,
    input  logic soak_Operation,
    input  logic wash_Operation,
    input  logic rinse_Operation,
    input  logic spin_Operation,
    output logic fill_Water,
    output logic heat_Water,
    output logic wash,
    output logic rinse_done,
    output logic spin_done,
    output logic valve_open,
    output logic heater_on,
    output logic motor_on,
    output logic motor_fast,
    output logic lid_pause,
    output logic fault
);

    state_t             state, state_next;
    phase_t             phase, phase_next;
    logic [CMD_W-1:0]   cmd;
    logic               multi, onehot, own, drum, advance;
    logic               cnt_en, cnt_clr, terminal;
    logic [CNT_W-1:0]   limit, count;
    logic [10:0]        out_d, out_q;

    always_comb begin
        cmd            = '0;
        cmd[CMD_FILL]  = water_Intake;
        cmd[CMD_HEAT]  = soak_Operation;
        cmd[CMD_WASH]  = wash_Operation;
        cmd[CMD_RINSE] = rinse_Operation;
        cmd[CMD_SPIN]  = spin_Operation;
    end

    assign multi   = (cmd & (cmd - CMD_W'(1))) != '0;
    assign onehot  = (cmd != '0) && !multi;
    assign drum    = (state == ST_WASH) || (state == ST_RINSE) || (state == ST_SPIN);
    assign advance = !drum || !lid;

    // phase tracks the current phase state and stays put through HOLD.
    always_comb begin
        own   = 1'b0;
        limit = FILL_CYCLES;
        case (phase)
            PH_FILL:  begin own = cmd[CMD_FILL];  limit = FILL_CYCLES;  end
            PH_HEAT:  begin own = cmd[CMD_HEAT];  limit = HEAT_CYCLES;  end
            PH_WASH:  begin own = cmd[CMD_WASH];  limit = WASH_CYCLES;  end
            PH_RINSE: begin own = cmd[CMD_RINSE]; limit = RINSE_CYCLES; end
            PH_SPIN:  begin own = cmd[CMD_SPIN];  limit = SPIN_CYCLES;  end
            default:  begin own = 1'b0;           limit = FILL_CYCLES;  end
        endcase
    end

    wm_phase_counter #(.CNT_W(CNT_W)) u_counter (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (cnt_clr),
        .enable   (cnt_en),
        .limit    (limit),
        .count    (count),
        .terminal (terminal)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            phase <= PH_NONE;
            out_q <= '0;
        end else begin
            state <= state_next;
            phase <= phase_next;
            out_q <= out_d;
        end
    end

    always_comb begin
        state_next = state;
        cnt_en     = 1'b0;
        cnt_clr    = 1'b1;
        if (multi) begin
            state_next = ST_ERROR;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (onehot) state_next = cmd_to_state(cmd);
                end
                ST_FILL, ST_HEAT, ST_WASH, ST_RINSE, ST_SPIN: begin
                    if (!own) begin
                        state_next = ST_IDLE;
                    end else if (!advance) begin
                        cnt_clr = 1'b0;
                    end else if (terminal) begin
                        state_next = ST_HOLD;
                    end else begin
                        cnt_en  = 1'b1;
                        cnt_clr = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!own) state_next = ST_IDLE;
                end
                default: begin
                    if (cmd == '0) state_next = ST_IDLE;
                end
            endcase
        end
        phase_next = is_phase(state_next) ? state_to_phase(state_next) : phase;
    end

    // Drum outputs follow the lid level sampled on the same edge.
    always_comb begin
        out_d     = '0;
        out_d[0]  = (state_next == ST_HOLD) && (phase_next == PH_FILL);
        out_d[1]  = (state_next == ST_HOLD) && (phase_next == PH_HEAT);
        out_d[2]  = (state_next == ST_HOLD) && (phase_next == PH_WASH);
        out_d[3]  = (state_next == ST_HOLD) && (phase_next == PH_RINSE);
        out_d[4]  = (state_next == ST_HOLD) && (phase_next == PH_SPIN);
        out_d[5]  = (state_next == ST_FILL);
        out_d[6]  = (state_next == ST_HEAT);
        out_d[7]  = ((state_next == ST_WASH) || (state_next == ST_RINSE)) && !lid;
        out_d[8]  = (state_next == ST_SPIN) && !lid;
        out_d[9]  = ((state_next == ST_WASH) || (state_next == ST_RINSE) ||
                     (state_next == ST_SPIN)) && lid;
        out_d[10] = (state_next == ST_ERROR);
    end

    assign fill_Water = out_q[0];
    assign heat_Water = out_q[1];
    assign wash       = out_q[2];
    assign rinse_done = out_q[3];
    assign spin_done  = out_q[4];
    assign valve_open = out_q[5];
    assign heater_on  = out_q[6];
    assign motor_on   = out_q[7];
    assign motor_fast = out_q[8];
    assign lid_pause  = out_q[9];
    assign fault      = out_q[10];

    a_limits_nonzero: assert property (@(posedge clock)
        (FILL_CYCLES != '0) && (HEAT_CYCLES != '0) && (WASH_CYCLES != '0) &&
        (RINSE_CYCLES != '0) && (SPIN_CYCLES != '0));

    a_count_in_range: assert property (@(posedge clock) disable iff (!reset_n)
        is_phase(state) |-> (count < limit));

endmodule

// File: doc/wm_phase_responder.md
Name: wm_phase_responder

Overview:
- Plant-side counterpart of the washing-machine controller FSM.
- Consumes the controller's one-hot operation commands: water_Intake, soak_Operation, wash_Operation, rinse_Operation, spin_Operation.
- Drives the actuators: valve, heater and drum motor.
- Returns the phase-completion inputs the controller waits on: fill_Water, heat_Water, wash, plus rinse_done and spin_done.
- Per-phase durations come from cycle counters. The lid interlock pauses drum phases. Command-protocol violations raise fault.

Parameters:
- CNT_W, 16, width of the phase counter.
- FILL_CYCLES, 16'd200, clocks of water_Intake before fill_Water; must be >= 1.
- HEAT_CYCLES, 16'd300, clocks of soak_Operation before heat_Water; must be >= 1.
- WASH_CYCLES, 16'd1000, active drum clocks before wash; must be >= 1.
- RINSE_CYCLES, 16'd600, active drum clocks before rinse_done; must be >= 1.
- SPIN_CYCLES, 16'd400, active drum clocks before spin_done; must be >= 1.

Ports:
- clock  in  1  single system clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- lid  in  1  1 = lid open
- water_Intake  in  1  fill command
- soak_Operation  in  1  heat/soak command
- wash_Operation  in  1  wash command
- rinse_Operation  in  1  rinse command
- spin_Operation  in  1  spin command
- fill_Water  out  1  fill complete (level)
- heat_Water  out  1  heat complete (level)
- wash  out  1  wash complete (level)
- rinse_done  out  1  rinse complete (level)
- spin_done  out  1  spin complete (level)
- valve_open  out  1  inlet valve drive
- heater_on  out  1  heater drive
- motor_on  out  1  drum slow drive (wash/rinse)
- motor_fast  out  1  drum fast drive (spin)
- lid_pause  out  1  drum phase active but paused by open lid
- fault  out  1  command protocol violation (sticky until cleared)

Behaviour:
- All outputs are registered. States: IDLE, FILL, HEAT, WASH, RINSE, SPIN, HOLD, ERROR. Internal phase register records which phase HOLD belongs to.
- Reset: reset_n low at an edge forces state=IDLE, count=0 and every output 0. Reset dominates all other inputs, including reset mid-phase, mid-HOLD or in ERROR.
- cmd = the five command inputs. onehot = exactly one bit set. multi = two or more bits set.
- multi sampled in any state -> ERROR next edge. Any phase or HOLD state is abandoned.
- IDLE: onehot -> matching phase state, count=0. Mapping: water_Intake->FILL, soak_Operation->HEAT, wash_Operation->WASH, rinse_Operation->RINSE, spin_Operation->SPIN.
- Phase state, own command still high:
  - FILL and HEAT always advance.
  - WASH, RINSE and SPIN advance only when lid=0. With lid=1, count holds, motor outputs are 0 and lid_pause=1.
  - On an advancing edge with count==LIMIT-1 -> HOLD, and the phase done output goes high.
  - Otherwise count increments.
- Latency: command first sampled at edge E0 with no pause -> done high after edge E0+LIMIT. Each paused edge adds one.
- Phase state, own command dropped (cmd==0) -> IDLE, count cleared, done never asserts (abort).
- Phase state, different single command replaces it -> IDLE for one cycle, then the new phase. No carry-over of count.
- Actuator outputs:
  - valve_open=1 only in FILL.
  - heater_on=1 only in HEAT.
  - motor_on=1 in WASH/RINSE with lid=0.
  - motor_fast=1 in SPIN with lid=0.
  - All actuator outputs are 0 in HOLD, IDLE and ERROR.
- HOLD: the done output stays high while its command stays high. Command low -> IDLE; done is low after that edge. At most one done output is high at any time.
- ERROR:
  - fault=1; all done and actuator outputs are 0.
  - Exit to IDLE on the first edge sampling cmd==0; fault clears on that edge.
  - Still multi or onehot -> remain in ERROR.
- Counter: CNT_W-bit unsigned, never wraps. LIMIT comparison is in CNT_W bits. A LIMIT of 0 is illegal and is flagged by a simulation assertion.
- lid has no effect in FILL, HEAT, HOLD, IDLE or ERROR.

Decomposition:
- Shared package wm_pkg:
  - 3-bit state encoding and phase enum, shared with the controller.
  - Default cycle-count constants.
  - Command bit-index constants.
- One sub-module, wm_phase_counter:
  - Synchronous clear, enable and LIMIT input.
  - Terminal flag (count==LIMIT-1) and CNT_W output.
- The top holds the FSM, decode and output registers.

Test Plan:
- FILL_CYCLES=4: reset, then water_Intake=1 from edge 0 -> valve_open=1 after edges 0..3; fill_Water=1 and valve_open=0 after edge 4. Drop water_Intake at edge 6 -> fill_Water=0 after edge 6.
- WASH_CYCLES=5, wash_Operation held, lid=1 for 3 cycles mid-phase -> lid_pause=1 and motor_on=0 during those 3 cycles; wash rises after edge E0+8.
- soak_Operation dropped after 2 of HEAT_CYCLES=4 -> heat_Water never rises; state IDLE; re-issue restarts full 4-cycle count.
- water_Intake and spin_Operation both 1 during FILL -> fault=1 next edge, all actuators 0. Both held 3 more cycles -> fault stays 1. All commands 0 -> fault=0 after that edge.
- reset_n=0 for one edge during SPIN with motor_fast=1 -> all outputs 0 after that edge; spin_Operation still high -> SPIN restarts from count 0 the following edge.
- Back-to-back: rinse completes (rinse_done=1), rinse_Operation drops the same edge spin_Operation rises -> one IDLE cycle, then SPIN; rinse_done and spin_done never high together.
